// File: rtl/l15_port_arbiter.sv
// rtl/l15_port_arbiter.sv - round-robin arbiter sharing the core->L1.5 port between imem and dmem
// One transaction in flight at a time; responses are steered to the owner, with a response watchdog.
module l15_port_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  imem_l15_rqtype,
  input  logic [2:0]  imem_l15_size,
  input  logic [31:0] imem_l15_address,
  input  logic        imem_l15_val,
  input  logic [4:0]  mem_l15_rqtype,
  input  logic [2:0]  mem_l15_size,
  input  logic [31:0] mem_l15_address,
  input  logic [63:0] mem_l15_data,
  input  logic        mem_l15_val,
  output logic        l15_imem_header_ack,
  output logic        l15_mem_header_ack,
  output logic        l15_imem_val,
  output logic        l15_mem_val,
  output logic [63:0] l15_rsp_data_0,
  output logic [63:0] l15_rsp_data_1,
  output logic [3:0]  l15_rsp_returntype,
  output logic [4:0]  core_l15_rqtype,
  output logic [2:0]  core_l15_size,
  output logic [31:0] core_l15_address,
  output logic [63:0] core_l15_data,
  output logic        core_l15_val,
  input  logic        l15_core_header_ack,
  input  logic        l15_core_val,
  input  logic [3:0]  l15_core_returntype,
  input  logic [63:0] l15_core_data_0,
  input  logic [63:0] l15_core_data_1,
  output logic        core_l15_req_ack,
  output logic        arb_owner,
  output logic        arb_timeout
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t          state_q;
  logic            owner_q;
  logic            last_grant_q;
  logic [3:0]      exp_rt_q;
  logic [WW-1:0]   wdog_q;
  logic [4:0]      hold_rqtype_q;
  logic [2:0]      hold_size_q;
  logic [31:0]     hold_addr_q;
  logic [63:0]     hold_data_q;

  logic            owner_val;
  logic            any_req;
  logic            winner;
  logic [4:0]      win_rqtype;
  logic [4:0]      live_rqtype;
  logic [2:0]      live_size;
  logic [31:0]     live_addr;
  logic [63:0]     live_data;
  logic            rsp_match;
  logic            wdog_fire;

  function automatic logic [3:0] rt_for(input logic [4:0] rq);
    case (rq)
      5'b00001: rt_for = 4'b0100;
      5'b10000: rt_for = 4'b0001;
      default:  rt_for = 4'b0000;
    endcase
  endfunction

  // On a tie the requester that was not served last wins.
  assign any_req    = imem_l15_val | mem_l15_val;
  assign winner     = (imem_l15_val & mem_l15_val) ? ~last_grant_q : mem_l15_val;
  assign win_rqtype = winner ? mem_l15_rqtype : imem_l15_rqtype;

  assign owner_val   = owner_q ? mem_l15_val : imem_l15_val;
  assign live_rqtype = owner_q ? mem_l15_rqtype  : imem_l15_rqtype;
  assign live_size   = owner_q ? mem_l15_size    : imem_l15_size;
  assign live_addr   = owner_q ? mem_l15_address : imem_l15_address;
  assign live_data   = owner_q ? mem_l15_data    : 64'd0;

  assign rsp_match = (state_q == S_RESP) && l15_core_val && (l15_core_returntype == exp_rt_q);
  assign wdog_fire = (state_q == S_RESP) && (TIMEOUT != 0) && !rsp_match &&
                     (wdog_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      exp_rt_q      <= 4'd0;
      wdog_q        <= '0;
      hold_rqtype_q <= 5'd0;
      hold_size_q   <= 3'd0;
      hold_addr_q   <= 32'd0;
      hold_data_q   <= 64'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q  <= winner;
            exp_rt_q <= rt_for(win_rqtype);
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (!owner_val) begin
            state_q <= S_IDLE;
          end else if (l15_core_header_ack) begin
            state_q       <= S_RESP;
            wdog_q        <= '0;
            hold_rqtype_q <= live_rqtype;
            hold_size_q   <= live_size;
            hold_addr_q   <= live_addr;
            hold_data_q   <= live_data;
          end
        end
        S_RESP: begin
          if (rsp_match || wdog_fire) begin
            last_grant_q <= owner_q;
            state_q      <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    l15_imem_header_ack = 1'b0;
    l15_mem_header_ack  = 1'b0;
    l15_imem_val        = 1'b0;
    l15_mem_val         = 1'b0;
    core_l15_val        = 1'b0;
    core_l15_rqtype     = 5'd0;
    core_l15_size       = 3'd0;
    core_l15_address    = 32'd0;
    core_l15_data       = 64'd0;
    case (state_q)
      S_REQ: begin
        core_l15_val     = owner_val;
        core_l15_rqtype  = live_rqtype;
        core_l15_size    = live_size;
        core_l15_address = live_addr;
        core_l15_data    = live_data;
        l15_imem_header_ack = owner_val & l15_core_header_ack & ~owner_q;
        l15_mem_header_ack  = owner_val & l15_core_header_ack &  owner_q;
      end
      S_RESP: begin
        core_l15_rqtype  = hold_rqtype_q;
        core_l15_size    = hold_size_q;
        core_l15_address = hold_addr_q;
        core_l15_data    = hold_data_q;
        l15_imem_val     = rsp_match & ~owner_q;
        l15_mem_val      = rsp_match &  owner_q;
      end
      default: ;
    endcase
  end

  // Every L1.5 response is consumed; only a matching one in RESP is forwarded.
  assign core_l15_req_ack   = l15_core_val;
  assign l15_rsp_data_0     = l15_core_data_0;
  assign l15_rsp_data_1     = l15_core_data_1;
  assign l15_rsp_returntype = l15_core_returntype;
  assign arb_owner          = owner_q;
  assign arb_timeout        = wdog_fire;

endmodule

// File: tb/tb_l15_port_arbiter.sv
// tb/tb_l15_port_arbiter.sv - scoreboard bench for l15_port_arbiter
// Stimulus pushes hand-timed expected output events; a negedge monitor pops and compares them.
module tb_l15_port_arbiter;

  logic        clk;
  logic        nrst;
  logic [4:0]  imem_l15_rqtype;
  logic [2:0]  imem_l15_size;
  logic [31:0] imem_l15_address;
  logic        imem_l15_val;
  logic [4:0]  mem_l15_rqtype;
  logic [2:0]  mem_l15_size;
  logic [31:0] mem_l15_address;
  logic [63:0] mem_l15_data;
  logic        mem_l15_val;
  logic        l15_imem_header_ack;
  logic        l15_mem_header_ack;
  logic        l15_imem_val;
  logic        l15_mem_val;
  logic [63:0] l15_rsp_data_0;
  logic [63:0] l15_rsp_data_1;
  logic [3:0]  l15_rsp_returntype;
  logic [4:0]  core_l15_rqtype;
  logic [2:0]  core_l15_size;
  logic [31:0] core_l15_address;
  logic [63:0] core_l15_data;
  logic        core_l15_val;
  logic        l15_core_header_ack;
  logic        l15_core_val;
  logic [3:0]  l15_core_returntype;
  logic [63:0] l15_core_data_0;
  logic [63:0] l15_core_data_1;
  logic        core_l15_req_ack;
  logic        arb_owner;
  logic        arb_timeout;

  l15_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .nrst(nrst),
    .imem_l15_rqtype(imem_l15_rqtype), .imem_l15_size(imem_l15_size),
    .imem_l15_address(imem_l15_address), .imem_l15_val(imem_l15_val),
    .mem_l15_rqtype(mem_l15_rqtype), .mem_l15_size(mem_l15_size),
    .mem_l15_address(mem_l15_address), .mem_l15_data(mem_l15_data), .mem_l15_val(mem_l15_val),
    .l15_imem_header_ack(l15_imem_header_ack), .l15_mem_header_ack(l15_mem_header_ack),
    .l15_imem_val(l15_imem_val), .l15_mem_val(l15_mem_val),
    .l15_rsp_data_0(l15_rsp_data_0), .l15_rsp_data_1(l15_rsp_data_1),
    .l15_rsp_returntype(l15_rsp_returntype),
    .core_l15_rqtype(core_l15_rqtype), .core_l15_size(core_l15_size),
    .core_l15_address(core_l15_address), .core_l15_data(core_l15_data), .core_l15_val(core_l15_val),
    .l15_core_header_ack(l15_core_header_ack), .l15_core_val(l15_core_val),
    .l15_core_returntype(l15_core_returntype),
    .l15_core_data_0(l15_core_data_0), .l15_core_data_1(l15_core_data_1),
    .core_l15_req_ack(core_l15_req_ack), .arb_owner(arb_owner), .arb_timeout(arb_timeout)
  );

  localparam logic [7:0] F_HI = 8'h80, F_HM = 8'h40, F_VI = 8'h20, F_VM = 8'h10;
  localparam logic [7:0] F_RA = 8'h08, F_TO = 8'h04, F_CV = 8'h02, F_OWN = 8'h01;
  localparam logic [63:0] RSP0 = 64'hC0DE_0000_5555_AAAA;

  typedef struct {
    int          cyc;
    logic [7:0]  fl;
    logic [4:0]  rq;
    logic [31:0] addr;
    logic [63:0] dat;
    logic [3:0]  rt;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  exp_t       mon_e;
  logic [7:0] mon_got;
  logic       mon_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [7:0] fl, input logic [4:0] rq, input logic [31:0] a,
                               input logic [63:0] d, input logic [3:0] rt);
    exp_t e;
    e.cyc = cyc; e.fl = fl; e.rq = rq; e.addr = a; e.dat = d; e.rt = rt;
    sb.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    mon_got = {l15_imem_header_ack, l15_mem_header_ack, l15_imem_val, l15_mem_val,
               core_l15_req_ack, arb_timeout, core_l15_val, arb_owner};
    if (nrst && (mon_got[7:1] != 7'd0)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event cyc=%0d flags=%b", cyc, mon_got);
      end else begin
        mon_e  = sb.pop_front();
        mon_ok = (mon_got == mon_e.fl) && (cyc == mon_e.cyc);
        if (mon_e.fl[1])
          mon_ok = mon_ok && (core_l15_rqtype == mon_e.rq) && (core_l15_address == mon_e.addr) &&
                   (core_l15_data == mon_e.dat);
        if (mon_e.fl[5] | mon_e.fl[4])
          mon_ok = mon_ok && (l15_rsp_data_0 == RSP0) && (l15_rsp_returntype == mon_e.rt);
        if (!mon_ok) begin
          n_err++;
          $display("FAIL event cyc=%0d: got flags=%b rq=%h addr=%h data=%h rt=%h; expected cyc=%0d flags=%b rq=%h addr=%h data=%h rt=%h",
                   cyc, mon_got, core_l15_rqtype, core_l15_address, core_l15_data, l15_rsp_returntype,
                   mon_e.cyc, mon_e.fl, mon_e.rq, mon_e.addr, mon_e.dat, mon_e.rt);
        end
      end
    end
  end

  // Called in the IDLE cycle with the owner's val already up; returns in the following IDLE cycle.
  task automatic serve(input bit who, input logic [4:0] rq, input logic [31:0] a,
                       input logic [63:0] d, input logic [3:0] ret);
    logic [7:0]  own;
    logic [63:0] ed;
    own = who ? F_OWN : 8'h00;
    ed  = who ? d : 64'd0;
    tick();
    push(F_CV | own, rq, a, ed, ret);
    tick();
    l15_core_header_ack = 1'b1;
    push(F_CV | own | (who ? F_HM : F_HI), rq, a, ed, ret);
    tick();
    l15_core_header_ack = 1'b0;
    tick();
    l15_core_val = 1'b1;
    l15_core_returntype = ret;
    push(F_RA | own | (who ? F_VM : F_VI), rq, a, ed, ret);
    tick();
    l15_core_val = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nrst = 1'b0;
    imem_l15_rqtype = 5'b10000; imem_l15_size = 3'd5; imem_l15_address = 32'h0000_1000;
    imem_l15_val = 1'b1;
    mem_l15_rqtype = 5'b00000; mem_l15_size = 3'd3; mem_l15_address = 32'h0000_2000;
    mem_l15_data = 64'h1111_2222_3333_4444; mem_l15_val = 1'b1;
    l15_core_header_ack = 1'b1; l15_core_val = 1'b0; l15_core_returntype = 4'd0;
    l15_core_data_0 = RSP0; l15_core_data_1 = 64'hFEED_FACE_0000_0001;

    // Reset state, with requests and header_ack deliberately active.
    repeat (2) tick();
    chk("rst_owner", 64'(arb_owner), 64'd0);
    chk("rst_core_val", 64'(core_l15_val), 64'd0);
    chk("rst_core_addr", 64'(core_l15_address), 64'd0);
    chk("rst_acks", 64'({l15_imem_header_ack, l15_mem_header_ack, core_l15_req_ack, arb_timeout}), 64'd0);
    l15_core_header_ack = 1'b0;
    imem_l15_val = 1'b0; mem_l15_val = 1'b0;
    nrst = 1'b1;
    tick();

    // Tie from reset: imem first, then strict alternation.
    imem_l15_val = 1'b1; mem_l15_val = 1'b1;
    serve(1'b0, 5'b10000, 32'h0000_1000, 64'd0, 4'b0001);
    serve(1'b1, 5'b00000, 32'h0000_2000, 64'h1111_2222_3333_4444, 4'b0000);
    serve(1'b0, 5'b10000, 32'h0000_1000, 64'd0, 4'b0001);
    serve(1'b1, 5'b00000, 32'h0000_2000, 64'h1111_2222_3333_4444, 4'b0000);
    imem_l15_val = 1'b0; mem_l15_val = 1'b0;
    tick();

    // dmem LOAD alone.
    mem_l15_rqtype = 5'b00000; mem_l15_address = 32'hA000_0040; mem_l15_data = 64'hDEAD_BEEF_0000_0001;
    mem_l15_val = 1'b1;
    serve(1'b1, 5'b00000, 32'hA000_0040, 64'hDEAD_BEEF_0000_0001, 4'b0000);
    mem_l15_val = 1'b0;

    // dmem STORE with an unrelated response arriving first.
    mem_l15_rqtype = 5'b00001; mem_l15_address = 32'hB000_0080; mem_l15_data = 64'h0123_4567_89AB_CDEF;
    mem_l15_val = 1'b1;
    tick();
    push(F_CV | F_OWN, 5'b00001, 32'hB000_0080, 64'h0123_4567_89AB_CDEF, 4'b0100);
    tick();
    l15_core_header_ack = 1'b1;
    push(F_CV | F_OWN | F_HM, 5'b00001, 32'hB000_0080, 64'h0123_4567_89AB_CDEF, 4'b0100);
    tick();
    l15_core_header_ack = 1'b0;
    mem_l15_val = 1'b0; mem_l15_address = 32'h0;
    #1;
    chk("resp_addr_held", 64'(core_l15_address), 64'hB000_0080);
    chk("resp_core_val", 64'(core_l15_val), 64'd0);
    tick();
    l15_core_val = 1'b1; l15_core_returntype = 4'b0011;
    push(F_RA | F_OWN, 5'd0, 32'd0, 64'd0, 4'b0011);
    tick();
    l15_core_returntype = 4'b0100;
    push(F_RA | F_OWN | F_VM, 5'd0, 32'd0, 64'd0, 4'b0100);
    tick();
    l15_core_val = 1'b0;

    // Watchdog: imem wins the tie, never answered; dmem served afterwards.
    imem_l15_rqtype = 5'b10000; imem_l15_address = 32'h0000_3000; imem_l15_val = 1'b1;
    mem_l15_rqtype = 5'b00001; mem_l15_address = 32'h0000_4000; mem_l15_data = 64'h5A5A_5A5A_0000_0002;
    mem_l15_val = 1'b1;
    tick();
    push(F_CV, 5'b10000, 32'h0000_3000, 64'd0, 4'd0);
    tick();
    l15_core_header_ack = 1'b1;
    push(F_CV | F_HI, 5'b10000, 32'h0000_3000, 64'd0, 4'd0);
    tick();
    l15_core_header_ack = 1'b0;
    imem_l15_val = 1'b0;
    repeat (7) tick();
    push(F_TO, 5'd0, 32'd0, 64'd0, 4'd0);
    tick();
    serve(1'b1, 5'b00001, 32'h0000_4000, 64'h5A5A_5A5A_0000_0002, 4'b0100);
    mem_l15_val = 1'b0;

    // Reset during RESP; a late response is consumed but not forwarded.
    mem_l15_rqtype = 5'b00000; mem_l15_address = 32'h0000_5000; mem_l15_val = 1'b1;
    tick();
    push(F_CV | F_OWN, 5'b00000, 32'h0000_5000, 64'h5A5A_5A5A_0000_0002, 4'd0);
    tick();
    l15_core_header_ack = 1'b1;
    push(F_CV | F_OWN | F_HM, 5'b00000, 32'h0000_5000, 64'h5A5A_5A5A_0000_0002, 4'd0);
    tick();
    l15_core_header_ack = 1'b0;
    mem_l15_val = 1'b0;
    tick();
    nrst = 1'b0;
    #1;
    chk("midrst_owner", 64'(arb_owner), 64'd0);
    chk("midrst_core_addr", 64'(core_l15_address), 64'd0);
    tick();
    nrst = 1'b1;
    tick();
    l15_core_val = 1'b1; l15_core_returntype = 4'b0000;
    push(F_RA, 5'd0, 32'd0, 64'd0, 4'd0);
    tick();
    l15_core_val = 1'b0;

    // imem withdraws in REQ: header_ack not forwarded, next tie still goes to imem.
    imem_l15_rqtype = 5'b10000; imem_l15_address = 32'h0000_6000; imem_l15_val = 1'b1;
    tick();
    push(F_CV, 5'b10000, 32'h0000_6000, 64'd0, 4'd0);
    tick();
    imem_l15_val = 1'b0;
    l15_core_header_ack = 1'b1;
    tick();
    l15_core_header_ack = 1'b0;
    imem_l15_address = 32'h0000_7000; imem_l15_val = 1'b1;
    mem_l15_rqtype = 5'b00000; mem_l15_address = 32'h0000_8000; mem_l15_data = 64'h0F0F_0F0F_0F0F_0F0F;
    mem_l15_val = 1'b1;
    serve(1'b0, 5'b10000, 32'h0000_7000, 64'd0, 4'b0001);
    imem_l15_val = 1'b0;
    serve(1'b1, 5'b00000, 32'h0000_8000, 64'h0F0F_0F0F_0F0F_0F0F, 4'b0000);
    mem_l15_val = 1'b0;

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
